// File: rtl/axon_mem_arbiter.sv
// Round-robin read arbiter for the axon memory with burst lock.
// Optional wait statistics: define AXON_ARB_WAIT_STATS_EN.
module axon_mem_arbiter #(
   parameter int NREQ      = 8,
   parameter int AW        = 10,
   parameter int DW        = 10,
   parameter int MAX_BURST = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NREQ-1:0]   io_req,
   input  logic [NREQ-1:0]   io_lock,
   input  logic [NREQ*AW-1:0] io_addr,
   output logic [NREQ-1:0]   io_gnt,
   output logic              io_aEna,
   output logic [AW-1:0]     io_aAddr,
   input  logic [DW-1:0]     io_aData,
   output logic [NREQ-1:0]   io_rValid,
   output logic [DW-1:0]     io_rData,
   output logic              io_busy,
   output logic [7:0]        io_maxWait
);

   localparam int PW = $clog2(NREQ);

   logic [PW-1:0] ptr;
   logic [PW-1:0] win;
   logic [PW-1:0] win_nxt;
   logic [3:0]    bcnt;
   logic [3:0]    bcnt_base;
   logic          hit;
   logic          grant;
   int unsigned   scan;

   always_comb begin
      win  = '0;
      hit  = 1'b0;
      scan = 0;
      for (int k = 0; k < NREQ; k++) begin
         scan = int'(ptr) + k;
         if (scan >= NREQ) scan = scan - NREQ;
         if (!hit && io_req[scan]) begin
            hit = 1'b1;
            win = PW'(scan);
         end
      end
   end

   assign grant   = hit && reset;
   assign win_nxt = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);

   always_comb begin
      io_gnt   = '0;
      io_aEna  = 1'b0;
      io_aAddr = '0;
      if (grant) begin
         io_gnt[win] = 1'b1;
         io_aEna     = 1'b1;
         io_aAddr    = io_addr[int'(win)*AW +: AW];
      end
   end

   // A locked owner that drops its request forfeits the running burst.
   assign bcnt_base = io_req[ptr] ? bcnt : 4'd0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr  <= '0;
         bcnt <= '0;
      end else if (hit) begin
         if (io_lock[win] && bcnt_base != 4'(MAX_BURST - 1)) begin
            ptr  <= win;
            bcnt <= bcnt_base + 4'd1;
         end else begin
            ptr  <= win_nxt;
            bcnt <= '0;
         end
      end else begin
         bcnt <= bcnt_base;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) io_rValid <= '0;
      else        io_rValid <= io_gnt;
   end

   assign io_rData = (|io_rValid) ? io_aData : '0;
   assign io_busy  = (|io_gnt) || (|io_rValid);

`ifdef AXON_ARB_WAIT_STATS_EN
   logic [7:0] wcnt [NREQ];
   logic [7:0] wmax;
   logic [7:0] max_wait;

   always_comb begin
      wmax = '0;
      for (int i = 0; i < NREQ; i++)
         if (wcnt[i] > wmax) wmax = wcnt[i];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREQ; i++) wcnt[i] <= '0;
         max_wait <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (io_gnt[i])
               wcnt[i] <= '0;
            else if (io_req[i] && wcnt[i] != 8'hFF)
               wcnt[i] <= wcnt[i] + 8'd1;
         end
         if (wmax > max_wait) max_wait <= wmax;
      end
   end

   assign io_maxWait = max_wait;
`else
   assign io_maxWait = 8'd0;
`endif

endmodule

// File: tb/tb_axon_mem_arbiter.sv
// Directed vector bench for axon_mem_arbiter.
// Expects io_maxWait=7 only when AXON_ARB_WAIT_STATS_EN is defined.
module tb_axon_mem_arbiter;

   localparam int NREQ = 8;
   localparam int AW   = 10;
   localparam int DW   = 10;
   localparam int NV   = 26;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [NREQ-1:0]  req = '0;
   logic [NREQ-1:0]  lock = '0;
   logic [NREQ*AW-1:0] addr;
   logic [DW-1:0]    adata = '0;
   logic [NREQ-1:0]  gnt;
   logic             aena;
   logic [AW-1:0]    aaddr;
   logic [NREQ-1:0]  rvalid;
   logic [DW-1:0]    rdata;
   logic             busy;
   logic [7:0]       maxwait;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [7:0] req;
      logic [7:0] lock;
      logic [7:0] gnt;
   } vec_t;

   vec_t tbl [NV];

   axon_mem_arbiter #(
      .NREQ(NREQ), .AW(AW), .DW(DW), .MAX_BURST(4)
   ) dut (
      .clock(clk),
      .reset(reset),
      .io_req(req),
      .io_lock(lock),
      .io_addr(addr),
      .io_gnt(gnt),
      .io_aEna(aena),
      .io_aAddr(aaddr),
      .io_aData(adata),
      .io_rValid(rvalid),
      .io_rData(rdata),
      .io_busy(busy),
      .io_maxWait(maxwait)
   );

   always #5 clk = ~clk;

   function automatic logic [AW-1:0] addr_of(input int i);
      return 10'h155 + 10'(i * 7);
   endfunction

   function automatic int idx_of(input logic [7:0] g);
      int r = 0;
      for (int i = 0; i < 8; i++) if (g[i]) r = i;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      logic [7:0] prev;
      logic [7:0] exp_wait;
      logic [7:0] walk;

      for (int i = 0; i < NREQ; i++) addr[i*AW +: AW] = addr_of(i);

      tbl[0]  = '{8'h01, 8'h00, 8'h01};
      tbl[1]  = '{8'h00, 8'h00, 8'h00};
      tbl[2]  = '{8'h80, 8'h00, 8'h80};
      tbl[3]  = '{8'h81, 8'h00, 8'h01};
      tbl[4]  = '{8'h80, 8'h00, 8'h80};
      walk = 8'h01;
      for (int i = 5; i < 13; i++) begin
         tbl[i] = '{8'hFF, 8'h00, walk};
         walk = walk << 1;
      end
      tbl[13] = '{8'h09, 8'h01, 8'h01};
      tbl[14] = '{8'h09, 8'h01, 8'h01};
      tbl[15] = '{8'h09, 8'h01, 8'h01};
      tbl[16] = '{8'h09, 8'h01, 8'h01};
      tbl[17] = '{8'h09, 8'h01, 8'h08};
      tbl[18] = '{8'h09, 8'h01, 8'h01};
      tbl[19] = '{8'h09, 8'h01, 8'h01};
      tbl[20] = '{8'h08, 8'h01, 8'h08};
      tbl[21] = '{8'h09, 8'h01, 8'h01};
      tbl[22] = '{8'h00, 8'h01, 8'h00};
      tbl[23] = '{8'h03, 8'h00, 8'h01};
      tbl[24] = '{8'h03, 8'h00, 8'h02};
      tbl[25] = '{8'h00, 8'h00, 8'h00};

      // held in reset with live requests
      req = 8'hFF;
      adata = 10'h3FF;
      #12;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_aena", 32'(aena), 32'h0);
      chk("rst_aaddr", 32'(aaddr), 32'h0);
      chk("rst_rvalid", 32'(rvalid), 32'h0);
      chk("rst_rdata", 32'(rdata), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_maxwait", 32'(maxwait), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      req = '0;

      prev = '0;
      for (int k = 0; k < NV; k++) begin
         @(negedge clk);
         req = tbl[k].req;
         lock = tbl[k].lock;
         adata = 10'h2AA ^ 10'(k > 1 ? k : 0);
         #1;
         chk($sformatf("v%0d_gnt", k), 32'(gnt), 32'(tbl[k].gnt));
         chk($sformatf("v%0d_aena", k), 32'(aena), 32'(|tbl[k].gnt));
         chk($sformatf("v%0d_aaddr", k), 32'(aaddr),
             tbl[k].gnt != 0 ? 32'(addr_of(idx_of(tbl[k].gnt))) : 32'h0);
         chk($sformatf("v%0d_rvalid", k), 32'(rvalid), 32'(prev));
         chk($sformatf("v%0d_rdata", k), 32'(rdata),
             prev != 0 ? 32'(adata) : 32'h0);
         chk($sformatf("v%0d_busy", k), 32'(busy),
             32'((|tbl[k].gnt) || (|prev)));
         prev = tbl[k].gnt;
      end

      // reset asserted while a return is showing clears it at once
      @(negedge clk);
      lock = '0;
      req = 8'h01;
      #1 chk("a_gnt", 32'(gnt), 32'h01);
      @(posedge clk);
      #1 chk("a_rvalid_pre", 32'(rvalid), 32'h01);
      req = '0;
      reset = 1'b0;
      #1;
      chk("a_rvalid_async", 32'(rvalid), 32'h0);
      chk("a_rdata_async", 32'(rdata), 32'h0);
      @(negedge clk);
      req = 8'h03;
      #1 chk("a_gnt_in_rst", 32'(gnt), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      #1 chk("a_first_arb", 32'(gnt), 32'h01);
      @(negedge clk);
      req = '0;
      #1 chk("a_rvalid_post", 32'(rvalid), 32'h01);

      // reset before the return edge discards the outstanding read
      @(negedge clk);
      req = 8'h01;
      #1 chk("b_gnt", 32'(gnt), 32'h01);
      #1 reset = 1'b0;
      @(posedge clk);
      #1 chk("b_rvalid_rst", 32'(rvalid), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      req = '0;
      #1 chk("b_rvalid_rel", 32'(rvalid), 32'h0);
      @(negedge clk);
      #1 chk("b_rvalid_rel2", 32'(rvalid), 32'h0);

      // wrap from ptr 0
      @(negedge clk);
      req = 8'h80;
      #1 chk("w_gnt80", 32'(gnt), 32'h80);
      @(negedge clk);
      req = 8'h81;
      #1;
      chk("w_gnt01", 32'(gnt), 32'h01);
      chk("w_rvalid", 32'(rvalid), 32'h80);

      // wait statistics from a fresh reset
      @(negedge clk);
      req = '0;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      req = 8'hFF;
      repeat (16) @(negedge clk);
      #1;
`ifdef AXON_ARB_WAIT_STATS_EN
      exp_wait = 8'd7;
`else
      exp_wait = 8'd0;
`endif
      chk("maxwait", 32'(maxwait), 32'(exp_wait));
      req = '0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
